// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory port arbiter: size codes,
// sequencer states and helpers for byte counts and load extension.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  // The reserved size code 2'b11 falls through to a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [2:0]  nbytes,
                                              input logic        sext);
    logic [31:0] v;
    case (nbytes)
      3'd1:    v = {{24{sext & raw[7]}}, raw[7:0]};
      3'd2:    v = {{16{sext & raw[15]}}, raw[15:0]};
      default: v = raw;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_prio_arb.sv
// Fixed-priority grant logic for the memory port: the load/store unit wins
// unless the fetch path has been passed over STARVE_MAX times in a row.
module mem_prio_arb
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_idle,
  input  logic i_if_req,
  input  logic i_ls_req,
  input  logic i_flush,
  input  logic i_if_done,
  input  logic i_ls_done,
  output logic o_grant_if,
  output logic o_grant_ls
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] r_starve;
  logic          w_if_elig;
  logic          w_ls_elig;
  logic          w_starved;

  // A requester whose done is showing this cycle is still holding its
  // request for one more cycle and must not be granted again.
  always_comb begin
    w_if_elig  = i_idle & i_if_req & ~i_if_done & ~i_flush;
    w_ls_elig  = i_idle & i_ls_req & ~i_ls_done;
    w_starved  = (r_starve == STARVE_LIM);
    o_grant_if = w_if_elig & (~w_ls_elig | w_starved);
    o_grant_ls = w_ls_elig & ~o_grant_if;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (i_en) begin
      if (!i_if_req || o_grant_if) begin
        r_starve <= '0;
      end else if (o_grant_ls && !w_starved) begin
        r_starve <= r_starve + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between instruction fetch and load/store,
// sequencing multi-byte accesses and assembling little-endian read data.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        ram_din,
  input  logic              io_buffer_full,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              flush,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_sext,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_base;
  logic [2:0]          r_n;
  logic                r_is_if;
  logic                r_sext;
  logic [31:0]         r_wdata;
  logic [2:0]          r_cnt;
  logic [31:0]         r_buf;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [7:0]          r_ram_dout;
  logic                r_ram_wr;
  logic                r_if_done;
  logic [31:0]         r_if_data;
  logic                r_ls_done;
  logic [31:0]         r_ls_rdata;

  logic                w_idle;
  logic                w_grant_if;
  logic                w_grant_ls;
  logic [2:0]          w_step;
  logic [1:0]          w_cap_idx;
  logic                w_rd_last;
  logic                w_if_abort;
  logic                w_wr_last;
  logic [31:0]         w_asm;

  mem_prio_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_arb (
    .clk        (clk),
    .rst        (rst),
    .i_en       (rdy),
    .i_idle     (w_idle),
    .i_if_req   (if_req),
    .i_ls_req   (ls_req),
    .i_flush    (flush),
    .i_if_done  (r_if_done),
    .i_ls_done  (r_ls_done),
    .o_grant_if (w_grant_if),
    .o_grant_ls (w_grant_ls)
  );

  // In RD, r_cnt counts edges since the grant, so w_step is the index j of
  // the upcoming edge E(j); byte j-2 arrives on ram_din in front of it.
  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    w_step     = r_cnt + 3'd1;
    w_cap_idx  = 2'(r_cnt - 3'd1);
    w_rd_last  = (r_state == ST_RD) && (w_step == (r_n + 3'd1));
    w_if_abort = (r_state == ST_RD) && r_is_if && flush;
    w_wr_last  = (r_state == ST_WR) && (r_cnt == r_n);
  end

  // The last byte is merged straight from ram_din so data and done leave
  // on the same edge.
  always_comb begin
    w_asm = r_buf;
    case (r_n)
      3'd1:    w_asm[7:0]   = ram_din;
      3'd2:    w_asm[15:8]  = ram_din;
      default: w_asm[31:24] = ram_din;
    endcase
  end

  // NOTE: every signal of a combinational block takes a default before the
  // case statement, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_ls) begin
          w_state_nxt = ls_we ? ST_WR : ST_RD;
        end else if (w_grant_if) begin
          w_state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        if (w_if_abort || w_rd_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR: begin
        if (w_wr_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= '0;
      r_n        <= '0;
      r_is_if    <= 1'b0;
      r_sext     <= 1'b0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_ram_addr <= '0;
      r_ram_dout <= '0;
      r_ram_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_if_data  <= '0;
      r_ls_done  <= 1'b0;
      r_ls_rdata <= '0;
    end else if (!rdy) begin
      r_ram_wr <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      r_ram_wr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ls) begin
            r_base     <= ls_addr;
            r_n        <= size_bytes(ls_size);
            r_is_if    <= 1'b0;
            r_sext     <= ls_sext;
            r_wdata    <= ls_wdata;
            r_cnt      <= '0;
            r_buf      <= '0;
            r_ram_addr <= ls_addr;
          end else if (w_grant_if) begin
            r_base     <= if_addr;
            r_n        <= 3'd4;
            r_is_if    <= 1'b1;
            r_sext     <= 1'b0;
            r_cnt      <= '0;
            r_buf      <= '0;
            r_ram_addr <= if_addr;
          end
        end
        ST_RD: begin
          if (!w_if_abort) begin
            r_cnt <= w_step;
            if (w_step < r_n) begin
              r_ram_addr <= r_base + ADDR_W'(w_step);
            end
            if (w_step >= 3'd2) begin
              r_buf[{w_cap_idx, 3'b000} +: 8] <= ram_din;
            end
            if (w_rd_last) begin
              if (r_is_if) begin
                r_if_done <= 1'b1;
                r_if_data <= w_asm;
              end else begin
                r_ls_done  <= 1'b1;
                r_ls_rdata <= extend_load(w_asm, r_n, r_sext);
              end
            end
          end
        end
        ST_WR: begin
          if (w_wr_last) begin
            r_ls_done <= 1'b1;
          end else if (!io_buffer_full) begin
            r_ram_wr   <= 1'b1;
            r_ram_addr <= r_base + ADDR_W'(r_cnt);
            r_ram_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
            r_cnt      <= r_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_addr = r_ram_addr;
  assign ram_dout = r_ram_dout;
  assign ram_wr   = r_ram_wr;
  assign if_done  = r_if_done;
  assign if_data  = r_if_data;
  assign ls_done  = r_ls_done;
  assign ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions
// followed by hand-written multi-cycle sequences.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [7:0]  ram_din;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        flush = 1'b0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = SZ_W;
  logic        ls_sext = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_done;
  logic [31:0] ls_rdata;

  mem_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ram_din(ram_din),
    .io_buffer_full(io_buffer_full), .ram_dout(ram_dout),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .if_req(if_req),
    .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .flush(flush), .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
    .ls_sext(ls_sext), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: registered read that freezes with the global enable.
  logic [7:0]  mem [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_a = '0;
  logic [7:0]  pre_d = '0;
  logic [39:0] wlog[$];

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    if (rdy) ram_din <= mem[ram_addr[11:0]];
    if (ram_wr) begin
      mem[ram_addr[11:0]] <= ram_dout;
      wlog.push_back({ram_addr, ram_dout});
    end
  end

  typedef struct {
    string       name;
    bit          is_if;
    bit          we;
    logic [1:0]  size;
    bit          sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_nb;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a  = a[11:0];
    pre_d  = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic wait_done(input bit is_if, output int lat);
    int t;
    t   = 0;
    lat = -1;
    while (lat < 0 && t < 60) begin
      tick();
      t++;
      if (is_if ? if_done : ls_done) lat = t;
    end
  endtask

  task automatic check_wlog(input string name, input logic [31:0] base,
                            input logic [31:0] wdata, input int n);
    check({name, " write count"}, wlog.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < wlog.size()) begin
        check({name, " write addr"}, wlog[k][39:8], base + 32'(k));
        check({name, " write byte"}, {24'b0, wlog[k][7:0]}, {24'b0, wdata[8*k +: 8]});
      end
    end
  endtask

  function automatic vec_t mk(input string n, input bit is_if, input bit we,
                              input logic [1:0] sz, input bit sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] ed, input int lat, input int nb);
    vec_t v;
    v.name = n; v.is_if = is_if; v.we = we; v.size = sz; v.sext = sx;
    v.addr = a; v.wdata = wd; v.exp_data = ed; v.exp_lat = lat; v.exp_nb = nb;
    return v;
  endfunction

  task automatic start_ls(input bit we, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] wd);
    ls_we = we; ls_size = sz; ls_sext = sx; ls_addr = a; ls_wdata = wd;
    ls_req = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    wlog.delete();
    if (v.is_if) begin
      if_addr = v.addr;
      if_req  = 1'b1;
    end else begin
      start_ls(v.we, v.size, v.sext, v.addr, v.wdata);
    end
    wait_done(v.is_if, lat);
    check({v.name, " latency"}, lat, v.exp_lat);
    if (v.is_if) check({v.name, " if_data"}, if_data, v.exp_data);
    else if (!v.we) check({v.name, " ls_rdata"}, ls_rdata, v.exp_data);
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();
    check({v.name, " single done pulse"}, {31'b0, v.is_if ? if_done : ls_done}, 32'd0);
    if (v.we) check_wlog(v.name, v.addr, v.wdata, v.exp_nb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    int  n_ls;
    bit  seen;
    logic [31:0] got;

    // Preload RAM while the DUT is held in reset.
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    poke(32'h200, 8'h80);
    poke(32'h210, 8'h01); poke(32'h211, 8'h80);
    poke(32'h220, 8'h78); poke(32'h221, 8'h56); poke(32'h222, 8'h34); poke(32'h223, 8'h12);
    poke(32'h233, 8'hAA); poke(32'h234, 8'hBB); poke(32'h235, 8'hCC); poke(32'h236, 8'hDD);
    poke(32'h241, 8'h34); poke(32'h242, 8'hF2);
    poke(32'h250, 8'h7F);
    poke(32'hFFE, 8'h11); poke(32'hFFF, 8'h22);
    poke(32'h000, 8'h33); poke(32'h001, 8'h44); poke(32'h002, 8'h55);

    check("reset ram_wr",   {31'b0, ram_wr}, 32'd0);
    check("reset ram_addr", ram_addr, 32'd0);
    check("reset ram_dout", {24'b0, ram_dout}, 32'd0);
    check("reset if_done",  {31'b0, if_done}, 32'd0);
    check("reset ls_done",  {31'b0, ls_done}, 32'd0);
    check("reset if_data",  if_data, 32'd0);
    check("reset ls_rdata", ls_rdata, 32'd0);
    rst = 1'b0;
    tick();

    vecs.push_back(mk("if_0x100",     1, 0, SZ_W,  0, 32'h100,      0,            32'h00000513, 6, 0));
    vecs.push_back(mk("lb_sext",      0, 0, SZ_B,  1, 32'h200,      0,            32'hFFFFFF80, 3, 0));
    vecs.push_back(mk("lbu",          0, 0, SZ_B,  0, 32'h200,      0,            32'h00000080, 3, 0));
    vecs.push_back(mk("lh_sext",      0, 0, SZ_H,  1, 32'h210,      0,            32'hFFFF8001, 4, 0));
    vecs.push_back(mk("lhu",          0, 0, SZ_H,  0, 32'h210,      0,            32'h00008001, 4, 0));
    vecs.push_back(mk("lw",           0, 0, SZ_W,  0, 32'h220,      0,            32'h12345678, 6, 0));
    vecs.push_back(mk("lw_size11",    0, 0, 2'b11, 1, 32'h220,      0,            32'h12345678, 6, 0));
    vecs.push_back(mk("lw_unaligned", 0, 0, SZ_W,  0, 32'h233,      0,            32'hDDCCBBAA, 6, 0));
    vecs.push_back(mk("lh_unaligned", 0, 0, SZ_H,  1, 32'h241,      0,            32'hFFFFF234, 4, 0));
    vecs.push_back(mk("lb_positive",  0, 0, SZ_B,  1, 32'h250,      0,            32'h0000007F, 3, 0));
    vecs.push_back(mk("lw_wrap",      0, 0, SZ_W,  1, 32'hFFFFFFFE, 0,            32'h44332211, 6, 0));
    vecs.push_back(mk("sh",           0, 1, SZ_H,  0, 32'h301,      32'h1234BEEF, 0,            4, 2));
    vecs.push_back(mk("lhu_after_sh", 0, 0, SZ_H,  0, 32'h301,      0,            32'h0000BEEF, 4, 0));
    vecs.push_back(mk("sb",           0, 1, SZ_B,  0, 32'h3FF,      32'h776655A5, 0,            3, 1));
    vecs.push_back(mk("lbu_after_sb", 0, 0, SZ_B,  0, 32'h3FF,      0,            32'h000000A5, 3, 0));
    vecs.push_back(mk("if_wrap",      1, 0, SZ_W,  0, 32'hFFFFFFFF, 0,            32'h55443322, 6, 0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // LS and IF requested in the same cycle: LS first, IF granted in LS's done cycle.
    if_addr = 32'h233;
    if_req  = 1'b1;
    start_ls(1'b0, SZ_W, 1'b0, 32'h220, 32'h0);
    wait_done(1'b0, lat);
    check("same_cycle ls latency", lat, 6);
    check("same_cycle ls_rdata", ls_rdata, 32'h12345678);
    check("same_cycle if not yet done", {31'b0, if_done}, 32'd0);
    ls_req = 1'b0;
    wait_done(1'b1, lat);
    check("same_cycle if latency after ls_done", lat, 6);
    check("same_cycle if_data", if_data, 32'hDDCCBBAA);
    if_req = 1'b0;
    tick();

    // Starvation: flush hides IF in each LS done cycle so LS keeps winning
    // until four consecutive LS grants force the fetch through.
    if_addr = 32'h100;
    if_req  = 1'b1;
    start_ls(1'b0, SZ_B, 1'b0, 32'h200, 32'h0);
    n_ls = 0;
    seen = 1'b0;
    got  = '0;
    for (int t = 0; t < 200 && !seen; t++) begin
      tick();
      flush = 1'b0;
      if (ls_done) begin
        n_ls++;
        flush = 1'b1;
      end
      if (if_done) begin
        seen = 1'b1;
        got  = if_data;
        if_req = 1'b0;
        ls_req = 1'b0;
      end
    end
    flush  = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
    check("starve if granted", {31'b0, seen}, 32'd1);
    check("starve ls grants before if", n_ls, 4);
    check("starve if_data", got, 32'h00000513);
    tick();
    tick();

    // Word store with io_buffer_full held high for three edges after byte 0.
    wlog.delete();
    start_ls(1'b1, SZ_W, 1'b0, 32'h00030000, 32'hDEADBEEF);
    tick();
    tick();
    io_buffer_full = 1'b1;
    tick(); tick(); tick();
    io_buffer_full = 1'b0;
    wait_done(1'b0, lat);
    check("stall store latency", lat + 5, 9);
    ls_req = 1'b0;
    check_wlog("stall store", 32'h00030000, 32'hDEADBEEF, 4);
    tick();

    // Flush two cycles into a fetch: no done, if_data untouched, then a clean refetch.
    if_addr = 32'h220;
    if_req  = 1'b1;
    tick();
    tick();
    flush  = 1'b1;
    if_req = 1'b0;
    tick();
    flush = 1'b0;
    seen  = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (if_done) seen = 1'b1;
    end
    check("flush no if_done", {31'b0, seen}, 32'd0);
    check("flush if_data kept", if_data, 32'h00000513);
    run_vec(mk("if_after_flush", 1, 0, SZ_W, 0, 32'h220, 0, 32'h12345678, 6, 0));

    // rdy low for four edges in the middle of a word load.
    start_ls(1'b0, SZ_W, 1'b0, 32'h233, 32'h0);
    tick(); tick(); tick();
    rdy = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("rdy load stall ram_wr", {31'b0, ram_wr}, 32'd0);
    end
    rdy = 1'b1;
    wait_done(1'b0, lat);
    check("rdy load latency", lat + 7, 10);
    check("rdy load ls_rdata", ls_rdata, 32'hDDCCBBAA);
    ls_req = 1'b0;
    tick();

    // rdy low for four edges in the middle of a word store.
    wlog.delete();
    start_ls(1'b1, SZ_W, 1'b0, 32'h500, 32'h11223344);
    tick(); tick(); tick();
    rdy = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("rdy store stall ram_wr", {31'b0, ram_wr}, 32'd0);
    end
    rdy = 1'b1;
    wait_done(1'b0, lat);
    check("rdy store latency", lat + 7, 10);
    ls_req = 1'b0;
    check_wlog("rdy store", 32'h500, 32'h11223344, 4);
    tick();

    // Reset in the middle of a store: two bytes already issued stay issued.
    wlog.delete();
    start_ls(1'b1, SZ_W, 1'b0, 32'h400, 32'hCAFEF00D);
    tick(); tick(); tick();
    rst    = 1'b1;
    ls_req = 1'b0;
    tick();
    rst = 1'b0;
    check("rst ram_wr",   {31'b0, ram_wr}, 32'd0);
    check("rst ram_addr", ram_addr, 32'd0);
    check("rst ram_dout", {24'b0, ram_dout}, 32'd0);
    check("rst if_done",  {31'b0, if_done}, 32'd0);
    check("rst ls_done",  {31'b0, ls_done}, 32'd0);
    check("rst if_data",  if_data, 32'd0);
    check("rst ls_rdata", ls_rdata, 32'd0);
    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (ls_done || if_done || ram_wr) seen = 1'b1;
    end
    check("rst no done or write after", {31'b0, seen}, 32'd0);
    check_wlog("rst store", 32'h400, 32'hCAFEF00D, 2);
    run_vec(mk("lw_after_rst", 0, 0, SZ_W, 0, 32'h220, 0, 32'h12345678, 6, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
